// File: rtl/sram_bitstream_reader_pkg.sv
// Shared types and constants for the SRAM bitstream reader.
//   BR_state_type   : reader control states
//   SRAM_ADDR_LIMIT : highest SRAM word address; the reader never wraps past it
//   clamp_consume   : limits a requested consume count to the 16-bit window
package sram_bitstream_reader_pkg;

  typedef enum logic {
    S_BR_IDLE,
    S_BR_STREAM
  } BR_state_type;

  localparam logic [17:0] SRAM_ADDR_LIMIT = 18'h3FFFF;
  localparam logic [4:0]  MAX_CONSUME     = 5'd16;

  function automatic logic [4:0] clamp_consume(input logic [4:0] count);
    return (count > MAX_CONSUME) ? MAX_CONSUME : count;
  endfunction

endpackage

// File: rtl/bitstream_word_fifo.sv
// Small 16-bit word FIFO holding prefetched SRAM words.
//   Clock, Resetn : clock, async active-low reset
//   flush         : synchronous clear, overrides push/pop
//   push/push_data: write one word
//   pop/pop_data  : pop_data shows the head word; pop advances it
//   count         : number of stored words
module bitstream_word_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             flush,
  input  logic             push,
  input  logic [15:0]      push_data,
  input  logic             pop,
  output logic [15:0]      pop_data,
  output logic [CNT_W-1:0] count
);

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/sram_bitstream_reader.sv
// Streams 16-bit SRAM words (MSB first) from Start_address into a 32-bit bit
// buffer and exposes a 16-bit look-ahead window for the decoder.
//   Clock, Resetn          : clock, async active-low reset
//   Start / Stop           : begin stream at Start_address / abort to idle
//   SRAM_address, SRAM_we_n, SRAM_read_data : SRAM read port (read-only use)
//   Bit_window, Window_valid : next 16 stream bits, valid when >=16 buffered
//   Consume, Consume_count : drop 0..16 bits from the window this cycle
//   Busy, Underrun_error   : streaming flag, sticky consume-without-data flag
module sram_bitstream_reader
  import sram_bitstream_reader_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic        Stop,
  input  logic [17:0] Start_address,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  output logic [15:0] Bit_window,
  output logic        Window_valid,
  input  logic        Consume,
  input  logic [4:0]  Consume_count,
  output logic        Busy,
  output logic        Underrun_error
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  BR_state_type            state, state_next;
  logic [READ_LATENCY-1:0] valid_pipe;
  logic                    exhausted;
  logic [31:0]             buffer, buffer_next;
  logic [5:0]              bit_count, bit_count_next;
  logic [5:0]              shift, rem;
  logic                    stop_evt, issue;
  logic                    fifo_flush, fifo_push, fifo_pop;
  logic [15:0]             fifo_data;
  logic [CNT_W-1:0]        fifo_count;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_BR_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    stop_evt   = 1'b0;
    case (state)
      S_BR_IDLE:   if (Start) state_next = S_BR_STREAM;
      S_BR_STREAM: begin
        if (Start) begin
          state_next = S_BR_STREAM;
        end else if (Stop) begin
          state_next = S_BR_IDLE;
          stop_evt   = 1'b1;
        end
      end
      default:     state_next = S_BR_IDLE;
    endcase
  end

  // Words in the FIFO plus reads still in the latency pipe never exceed
  // FIFO_DEPTH, so every tagged return has a slot waiting for it.
  always_comb begin
    issue = 1'b0;
    if (state == S_BR_STREAM && !Start && !Stop && !exhausted &&
        (32'(fifo_count) + 32'($countones(valid_pipe)) < FIFO_DEPTH))
      issue = 1'b1;
  end

  // Consume first, then top up with one word whenever the remainder leaves
  // room for it; the new word lands just below the surviving bits.
  always_comb begin
    shift = '0;
    if (Consume && Window_valid) shift = {1'b0, clamp_consume(Consume_count)};
    rem            = bit_count - shift;
    buffer_next    = buffer << shift;
    bit_count_next = rem;
    fifo_pop       = 1'b0;
    if (rem <= 6'd16 && fifo_count != '0) begin
      fifo_pop       = 1'b1;
      buffer_next    = buffer_next | ({fifo_data, 16'h0000} >> rem);
      bit_count_next = rem + 6'd16;
    end
  end

  assign fifo_flush = Start || stop_evt;
  assign fifo_push  = valid_pipe[READ_LATENCY-1];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      SRAM_address <= '0;
      exhausted    <= 1'b0;
      buffer       <= '0;
      bit_count    <= '0;
      valid_pipe   <= '0;
    end else if (Start) begin
      SRAM_address <= Start_address;
      exhausted    <= 1'b0;
      buffer       <= '0;
      bit_count    <= '0;
      valid_pipe   <= '0;
    end else if (stop_evt) begin
      // Clearing the tag pipe drops reads already in flight.
      buffer       <= '0;
      bit_count    <= '0;
      valid_pipe   <= '0;
    end else begin
      valid_pipe <= (valid_pipe << 1) | READ_LATENCY'(issue);
      if (issue) begin
        // The last address is read once, then the address parks there.
        if (SRAM_address == SRAM_ADDR_LIMIT) exhausted <= 1'b1;
        else                                 SRAM_address <= SRAM_address + 1'b1;
      end
      buffer    <= buffer_next;
      bit_count <= bit_count_next;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)                      Underrun_error <= 1'b0;
    else if (Start)                   Underrun_error <= 1'b0;
    else if (Consume && !Window_valid) Underrun_error <= 1'b1;
  end

  bitstream_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .push_data(SRAM_read_data),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .count    (fifo_count)
  );

  assign SRAM_we_n    = 1'b1;
  assign Bit_window   = buffer[31:16];
  assign Window_valid = (bit_count >= 6'd16);
  assign Busy         = (state == S_BR_STREAM);

endmodule

// File: tb/tb_sram_bitstream_reader.sv
module tb_sram_bitstream_reader;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [17:0] LIMIT      = 18'h3FFFF;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b1;
  logic        Start = 1'b0;
  logic        Stop = 1'b0;
  logic        Consume = 1'b0;
  logic [4:0]  Consume_count = '0;
  logic [17:0] Start_address = '0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic        SRAM_we_n;
  logic [15:0] Bit_window;
  logic        Window_valid;
  logic        Busy;
  logic        Underrun_error;

  logic [15:0] mem [262144];
  logic [15:0] rd_stage1, rd_stage2;

  int errors = 0;
  int checks = 0;

  // Reference: the stream as a flat bit sequence, oldest bit at index 0.
  bit exp_bits[$];
  bit next_bits[$];
  bit exp_ur = 1'b0;
  bit exp_busy = 1'b0;

  sram_bitstream_reader #(.READ_LATENCY(2), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .Clock         (Clock),
    .Resetn        (Resetn),
    .Start         (Start),
    .Stop          (Stop),
    .Start_address (Start_address),
    .SRAM_read_data(SRAM_read_data),
    .SRAM_address  (SRAM_address),
    .SRAM_we_n     (SRAM_we_n),
    .Bit_window    (Bit_window),
    .Window_valid  (Window_valid),
    .Consume       (Consume),
    .Consume_count (Consume_count),
    .Busy          (Busy),
    .Underrun_error(Underrun_error)
  );

  always #5 Clock = ~Clock;

  // Two-cycle SRAM: address seen at one edge, data valid after the next.
  always @(posedge Clock) begin
    rd_stage1 <= mem[SRAM_address];
    rd_stage2 <= rd_stage1;
  end
  assign SRAM_read_data = rd_stage2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [15:0] head_window();
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15-i] = exp_bits[i];
    return w;
  endfunction

  task automatic build_stream(input logic [17:0] addr);
    int unsigned a;
    a = 32'(addr);
    next_bits.delete();
    for (int unsigned w = 0; w < 300 && a + w <= 32'(LIMIT); w++)
      for (int b = 15; b >= 0; b--) next_bits.push_back(mem[18'(a + w)][b]);
  endtask

  task automatic start_stream(input logic [17:0] addr);
    build_stream(addr);
    Start_address = addr;
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!Window_valid && n < 40) begin
      step();
      n++;
    end
    chk(name, 32'(Window_valid), 1);
  endtask

  // Monitor / scoreboard: compares every presented window against the head
  // of the expected bit sequence, then advances the model for this edge.
  always @(negedge Clock) begin
    int unsigned n;
    if (!Resetn) begin
      exp_bits.delete();
      exp_ur   = 1'b0;
      exp_busy = 1'b0;
    end else begin
      chk("busy", 32'(Busy), 32'(exp_busy));
      chk("underrun", 32'(Underrun_error), 32'(exp_ur));
      chk("fifo_bound", 32'(dut.u_fifo.count <= FIFO_DEPTH), 1);
      if (Window_valid) begin
        chk("window_avail", 32'(exp_bits.size() >= 16), 1);
        if (exp_bits.size() >= 16) chk("window", 32'(Bit_window), 32'(head_window()));
      end
      if (Start) begin
        exp_bits = next_bits;
        exp_ur   = 1'b0;
        exp_busy = 1'b1;
      end else begin
        if (Stop && exp_busy) begin
          exp_bits.delete();
          exp_busy = 1'b0;
        end else if (Consume && Window_valid) begin
          n = (Consume_count > 5'd16) ? 16 : 32'(Consume_count);
          repeat (n) if (exp_bits.size() > 0) void'(exp_bits.pop_front());
        end
        if (Consume && !Window_valid) exp_ur = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [17:0] a;
    for (int i = 0; i < 262144; i++) mem[i] = 16'($urandom);

    // Reset values
    #2 Resetn = 1'b0;
    #1;
    chk("rst_addr", 32'(SRAM_address), 0);
    chk("rst_we_n", 32'(SRAM_we_n), 1);
    chk("rst_window", 32'(Bit_window), 0);
    chk("rst_valid", 32'(Window_valid), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_underrun", 32'(Underrun_error), 0);
    repeat (2) @(posedge Clock);
    #1 Resetn = 1'b1;
    step();

    // Latency, prefetch depth, partial consumes
    mem[0] = 16'hA5C3;
    mem[1] = 16'h1234;
    start_stream(18'd0);
    repeat (3) step();
    chk("latency_pre", 32'(Window_valid), 0);
    step();
    chk("latency", 32'(Window_valid), 1);
    chk("first_window", 32'(Bit_window), 32'h0000A5C3);
    repeat (10) step();
    // two words sit in the 32-bit buffer on top of a full FIFO
    chk("prefetch_stop", 32'(SRAM_address), FIFO_DEPTH + 2);
    Consume = 1'b1; Consume_count = 5'd4;
    step();
    Consume = 1'b0;
    chk("after_4", 32'(Bit_window), 32'h00005C31);
    Consume = 1'b1; Consume_count = 5'd12;
    step();
    Consume = 1'b0;
    chk("after_16", 32'(Bit_window), 32'h00001234);

    // Underrun: consume before any data
    start_stream(18'd0);
    step();
    Consume = 1'b1; Consume_count = 5'd8;
    step();
    Consume = 1'b0;
    wait_valid("ur_valid");
    chk("ur_flag", 32'(Underrun_error), 1);
    chk("ur_no_shift", 32'(Bit_window), 32'h0000A5C3);
    start_stream(18'd0);
    chk("ur_cleared", 32'(Underrun_error), 0);

    // Stop with reads in flight, then restart elsewhere
    step();
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    step();
    start_stream(18'h00100);
    wait_valid("restart_valid");
    chk("restart_window", 32'(Bit_window), 32'(mem[18'h00100]));
    repeat (3) begin
      Consume = 1'b1; Consume_count = 5'd16;
      step();
    end
    Consume = 1'b0;

    // Full-rate ramp
    for (int k = 0; k < 300; k++) mem[18'h00200 + 18'(k)] = 16'(k);
    start_stream(18'h00200);
    wait_valid("ramp_prime");
    for (int k = 0; k < 256; k++) begin
      chk("ramp_valid", 32'(Window_valid), 1);
      chk("ramp_word", 32'(Bit_window), k);
      Consume = 1'b1; Consume_count = 5'd16;
      step();
    end
    Consume = 1'b0;

    // End of memory
    start_stream(LIMIT - 18'd1);
    wait_valid("end_valid");
    repeat (4) step();
    chk("end_addr_hold", 32'(SRAM_address), 32'(LIMIT));
    chk("end_word0", 32'(Bit_window), 32'(mem[LIMIT - 18'd1]));
    Consume = 1'b1; Consume_count = 5'd16;
    step();
    chk("end_word1_valid", 32'(Window_valid), 1);
    chk("end_word1", 32'(Bit_window), 32'(mem[LIMIT]));
    step();
    Consume = 1'b0;
    repeat (4) step();
    chk("end_drained", 32'(Window_valid), 0);
    chk("end_addr_final", 32'(SRAM_address), 32'(LIMIT));

    // Randomized streams, including clamped counts and underruns
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 1) a = LIMIT - 18'($urandom_range(0, 5));
      else            a = 18'($urandom);
      start_stream(a);
      for (int c = 0; c < 80; c++) begin
        Consume       = ($urandom_range(0, 9) < 7);
        Consume_count = 5'($urandom_range(0, 31));
        step();
      end
      Consume = 1'b0;
      Stop = 1'b1;
      step();
      Stop = 1'b0;
      step();
    end

    // Asynchronous reset mid-stream
    start_stream(18'h00200);
    wait_valid("arst_valid");
    repeat (3) step();
    #2 Resetn = 1'b0;
    #1;
    chk("arst_addr", 32'(SRAM_address), 0);
    chk("arst_window", 32'(Bit_window), 0);
    chk("arst_valid", 32'(Window_valid), 0);
    chk("arst_busy", 32'(Busy), 0);
    chk("arst_underrun", 32'(Underrun_error), 0);
    chk("arst_we_n", 32'(SRAM_we_n), 1);
    @(posedge Clock);
    #1 Resetn = 1'b1;
    repeat (3) step();
    chk("arst_idle_busy", 32'(Busy), 0);
    chk("arst_idle_valid", 32'(Window_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
